// File: rtl/checker_defs.sv
// Shared encodings for the data-memory write checker.
package checker_defs;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_ADDR    = 2'd1,
        FC_DATA    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fail_code_t;

endpackage

// File: rtl/mem_write_checker.sv
// Self-check monitor for the core's data-memory store bus. Walks an ordered
// table of expected (address, data) stores, skips stores into a scratch
// window, and latches a sticky PASS / FAIL / TIMEOUT verdict.
module mem_write_checker
    import checker_defs::*;
#(
    parameter int                         ADDR_W      = 32,
    parameter int                         DATA_W      = 32,
    parameter int                         N_CHECKS    = 1,
    parameter logic [N_CHECKS*ADDR_W-1:0] EXP_ADDRS   = 32'd100,
    parameter logic [N_CHECKS*DATA_W-1:0] EXP_DATA    = 32'd25,
    parameter logic [ADDR_W-1:0]          IGN_BASE    = 32'd96,
    parameter logic [ADDR_W-1:0]          IGN_MASK    = 32'hFFFFFFFF,
    parameter int                         TIMEOUT_CYC = 1000
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            MemWrite,
    input  logic [ADDR_W-1:0]               DataAdr,
    input  logic [DATA_W-1:0]               WriteData,
    output logic                            done,
    output logic                            pass,
    output logic [1:0]                      fail_code,
    output logic [$clog2(N_CHECKS+1)-1:0]   match_count,
    output logic [ADDR_W-1:0]               fail_addr,
    output logic [DATA_W-1:0]               fail_data,
    output logic [31:0]                     cycle_count
);

    localparam int          IW      = $clog2(N_CHECKS + 1);
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);

    state_t          r_state, w_next_state;
    fail_code_t      r_fail_code, w_next_code;
    logic [IW-1:0]   r_idx;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_data;
    logic [31:0]     r_cycle_count;

    logic [ADDR_W-1:0] w_exp_addr;
    logic [DATA_W-1:0] w_exp_data;
    logic            w_addr_hit, w_match, w_ignore;
    logic            w_inc_idx, w_capture;

    // Table lookup: the index (== match_count) selects the current entry.
    // idx reaches N_CHECKS only in PASS, where the lookup is unused.
    always_comb begin
        w_exp_addr = EXP_ADDRS[ADDR_W-1:0];
        w_exp_data = EXP_DATA[DATA_W-1:0];
        for (int i = 0; i < N_CHECKS; i++) begin
            if (r_idx == IW'(i)) begin
                w_exp_addr = EXP_ADDRS[i*ADDR_W +: ADDR_W];
                w_exp_data = EXP_DATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_addr_hit = (DataAdr == w_exp_addr);
    assign w_match    = w_addr_hit && (WriteData == w_exp_data);
    assign w_ignore   = ((DataAdr & IGN_MASK) == (IGN_BASE & IGN_MASK));

    // Next state: match beats ignore beats fail; any terminal event this
    // cycle beats the timeout.
    always_comb begin
        w_next_state = r_state;
        w_next_code  = r_fail_code;
        w_inc_idx    = 1'b0;
        w_capture    = 1'b0;
        if (r_state == ST_RUN) begin
            if (MemWrite) begin
                if (w_match) begin
                    w_inc_idx = 1'b1;
                    if (r_idx == IW'(N_CHECKS - 1))
                        w_next_state = ST_PASS;
                end else if (!w_ignore) begin
                    w_next_state = ST_FAIL;
                    w_capture    = 1'b1;
                    w_next_code  = w_addr_hit ? FC_DATA : FC_ADDR;
                end
            end
            if (w_next_state == ST_RUN && TIMEOUT_CYC != 0 && r_cycle_count == TO_LAST) begin
                w_next_state = ST_TIMEOUT;
                w_next_code  = FC_TIMEOUT;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_RUN;
        else       r_state <= w_next_state;
    end

    // Counters and diagnostics. cycle_count only advances on cycles that
    // stay in RUN, so it reads the deciding cycle's count once terminal.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_fail_code   <= FC_NONE;
            r_fail_addr   <= '0;
            r_fail_data   <= '0;
            r_cycle_count <= '0;
        end else begin
            r_fail_code <= w_next_code;
            if (w_inc_idx)
                r_idx <= r_idx + IW'(1);
            if (w_capture) begin
                r_fail_addr <= DataAdr;
                r_fail_data <= WriteData;
            end
            if (r_state == ST_RUN && w_next_state == ST_RUN && r_cycle_count != '1)
                r_cycle_count <= r_cycle_count + 32'd1;
        end
    end

    assign done        = (r_state != ST_RUN);
    assign pass        = (r_state == ST_PASS);
    assign fail_code   = r_fail_code;
    assign match_count = r_idx;
    assign fail_addr   = r_fail_addr;
    assign fail_data   = r_fail_data;
    assign cycle_count = r_cycle_count;

endmodule
